// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg: shared FSM state type, counter sizing and operand magnitude helper
// Contents: state_e (IDLE/BUSY/DONE), MAX_W (widest supported operand), cnt_w(), abs_mag()
package seq_multiplier_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam int MAX_W = 64;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // value arrives sign-extended; unsigned callers simply pass is_signed=0 and keep the low bits
  function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value, input logic is_signed);
    return (is_signed && value[MAX_W-1]) ? -value : value;
  endfunction
endpackage

// File: rtl/seq_multiplier_pp.sv
// seq_multiplier_pp: combinational partial product of one multiplier slice, shifted and added to the accumulator
// Ports: mcand (multiplicand magnitude), shift (bit position of slice), slice (BitsPerCycle multiplier bits),
//        acc_in (current accumulator), acc_out (accumulator plus shifted partial product)
module seq_multiplier_pp #(
  parameter int Width = 8,
  parameter int BitsPerCycle = 1
) (
  input  logic [Width-1:0]         mcand,
  input  logic [$clog2(Width)-1:0] shift,
  input  logic [BitsPerCycle-1:0]  slice,
  input  logic [2*Width-1:0]       acc_in,
  output logic [2*Width-1:0]       acc_out
);
  localparam int W2 = 2 * Width;
  assign acc_out = acc_in + ((W2'(mcand) * W2'(slice)) << shift);
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier retiring BitsPerCycle multiplier bits per cycle, valid/ready on both sides
// Ports: clk_i, rst_ni (async active-low); in_valid_i/in_ready_o with data_in1_i (multiplicand), data_in2_i (multiplier),
//        signed_i (two's complement mode); data_out_o (2*Width product) with data_out_valid_o/data_out_ready_i
// Option: define SEQ_MULTIPLIER_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int Width = 8,
  parameter int BitsPerCycle = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [Width-1:0]   data_in1_i,
  input  logic [Width-1:0]   data_in2_i,
  input  logic               signed_i,
  output logic [2*Width-1:0] data_out_o,
  output logic               data_out_valid_o,
  input  logic               data_out_ready_i
);
  localparam int N = Width / BitsPerCycle;
  localparam int CntW = cnt_w(N);
  localparam int ShW = $clog2(Width);
  state_e state, state_nxt;
  logic [Width-1:0] mcand, b, b_rem;
  logic [2*Width-1:0] acc, acc_nxt;
  logic [CntW-1:0] cnt;
  logic [ShW-1:0] shift;
  logic [MAX_W-1:0] sx1, sx2;
  logic neg, last;
  assign in_ready_o = state == IDLE;
  assign data_out_valid_o = state == DONE;
  assign sx1 = MAX_W'($signed(data_in1_i));
  assign sx2 = MAX_W'($signed(data_in2_i));
  assign shift = ShW'(cnt * BitsPerCycle);
  assign b_rem = b >> BitsPerCycle;
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
  assign last = (cnt == CntW'(N - 1)) || (b_rem == '0);
`else
  assign last = cnt == CntW'(N - 1);
`endif
  seq_multiplier_pp #(.Width(Width), .BitsPerCycle(BitsPerCycle)) u_pp (
    .mcand  (mcand),
    .shift  (shift),
    .slice  (b[BitsPerCycle-1:0]),
    .acc_in (acc),
    .acc_out(acc_nxt)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = in_valid_i ? BUSY : IDLE;
      BUSY: state_nxt = last ? DONE : BUSY;
      DONE: state_nxt = data_out_ready_i ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      mcand <= '0;
      b <= '0;
      acc <= '0;
      cnt <= '0;
      neg <= 1'b0;
      data_out_o <= '0;
    end else if (state == IDLE && in_valid_i) begin
      mcand <= Width'(abs_mag(sx1, signed_i));
      b <= Width'(abs_mag(sx2, signed_i));
      neg <= signed_i & (data_in1_i[Width-1] ^ data_in2_i[Width-1]);
      acc <= '0;
      cnt <= '0;
    end else if (state == BUSY) begin
      acc <= acc_nxt;
      b <= b_rem;
      cnt <= cnt + 1'b1;
      if (last) data_out_o <= neg ? -acc_nxt : acc_nxt;
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random checks of an 8x8 (1 bit/cycle) and a 16x16 (4 bits/cycle) instance
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v8 = 1'b0, r8, s8 = 1'b0, ov8, or8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] d8;
  logic v16 = 1'b0, r16, s16 = 1'b0, ov16, or16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] d16;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.Width(8), .BitsPerCycle(1)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v8), .in_ready_o(r8),
    .data_in1_i(a8), .data_in2_i(b8), .signed_i(s8),
    .data_out_o(d8), .data_out_valid_o(ov8), .data_out_ready_i(or8)
  );

  seq_multiplier #(.Width(16), .BitsPerCycle(4)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v16), .in_ready_o(r16),
    .data_in1_i(a16), .data_in2_i(b16), .signed_i(s16),
    .data_out_o(d16), .data_out_valid_o(ov16), .data_out_ready_i(or16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit big);
    return big ? r16 : r8;
  endfunction

  function automatic logic vld(input bit big);
    return big ? ov16 : ov8;
  endfunction

  function automatic logic [31:0] dout(input bit big);
    return big ? d16 : {16'h0, d8};
  endfunction

  // product as plain integer arithmetic, wrapped to 2*width bits
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input bit s, input bit big);
    longint x, y, p;
    logic [7:0] a_lo, b_lo;
    a_lo = a[7:0];
    b_lo = b[7:0];
    if (big) begin
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
    end else begin
      x = s ? longint'($signed(a_lo)) : longint'(a_lo);
      y = s ? longint'($signed(b_lo)) : longint'(b_lo);
    end
    p = x * y;
    return big ? p[31:0] : {16'h0, p[15:0]};
  endfunction

  function automatic int exp_latency(input logic [15:0] b, input bit s, input bit big);
    int w, bpc, h;
    longint y, m;
    w = big ? 16 : 8;
    bpc = big ? 4 : 1;
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    y = model(16'h1, b, s, big);
    if (!big && s && y[15]) y = y - 65536;
    m = y < 0 ? -y : y;
    h = -1;
    for (int i = 0; i < w; i++) if (m[i]) h = i;
    return h < 0 ? 1 : (h + bpc) / bpc;
`else
    y = 0;
    m = y;
    h = int'(m);
    return w / bpc + h;
`endif
  endfunction

  task automatic drive_in(input bit big, input bit v, input logic [15:0] a, input logic [15:0] b, input bit s);
    if (big) begin
      v16 = v; a16 = a; b16 = b; s16 = s;
    end else begin
      v8 = v; a8 = a[7:0]; b8 = b[7:0]; s8 = s;
    end
  endtask

  task automatic txn(input bit big, input logic [15:0] a, input logic [15:0] b, input bit s,
                     input string tag, input int hold);
    logic [31:0] exp;
    int lat, wt;
    exp = model(a, b, s, big);
    wt = 0;
    while (!rdy(big) && wt < 20) begin
      @(posedge clk); #1;
      wt++;
    end
    chk({tag, "_ready_wait"}, 32'(rdy(big)), 32'd1);
    drive_in(big, 1'b1, a, b, s);
    @(posedge clk); #1;
    drive_in(big, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    chk({tag, "_busy_ready"}, 32'(rdy(big)), 32'd0);
    lat = 0;
    while (!vld(big) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_latency(b, s, big)));
    chk({tag, "_product"}, dout(big), exp);
    for (int i = 0; i < hold; i++) begin
      drive_in(big, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(vld(big)), 32'd1);
      chk({tag, "_hold_data"}, dout(big), exp);
      chk({tag, "_hold_ready"}, 32'(rdy(big)), 32'd0);
    end
    drive_in(big, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    if (big) or16 = 1'b1; else or8 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    or8 = 1'b0;
    chk({tag, "_post_valid"}, 32'(vld(big)), 32'd0);
    chk({tag, "_post_ready"}, 32'(rdy(big)), 32'd1);
    chk({tag, "_post_data"}, dout(big), exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready8", 32'(r8), 32'd1);
    chk("rst_valid8", 32'(ov8), 32'd0);
    chk("rst_data8", 32'(d8), 32'd0);
    chk("rst_ready16", 32'(r16), 32'd1);
    chk("rst_valid16", 32'(ov16), 32'd0);
    chk("rst_data16", d16, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 16'd2, 16'd7, 1'b0, "u2x7", 0);
    txn(1'b0, 16'd211, 16'd98, 1'b0, "u211x98", 0);
    txn(1'b0, 16'd123, 16'd77, 1'b0, "u123x77", 0);
    txn(1'b0, 16'd255, 16'd255, 1'b0, "u255x255", 0);
    txn(1'b0, 16'd0, 16'd0, 1'b0, "u0x0", 0);
    txn(1'b0, 16'hFD, 16'd5, 1'b1, "s_m3x5", 0);
    txn(1'b0, 16'h80, 16'h80, 1'b1, "s_m128xm128", 0);
    txn(1'b0, 16'h80, 16'h7F, 1'b1, "s_m128x127", 0);
    txn(1'b0, 16'h80, 16'h80, 1'b0, "u128x128", 0);
    txn(1'b0, 16'd13, 16'd11, 1'b0, "backpressure", 5);
    drive_in(1'b0, 1'b1, 16'd211, 16'd98, 1'b0);
    @(posedge clk); #1;
    drive_in(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov8), 32'd0);
    chk("midrst_ready", 32'(r8), 32'd1);
    chk("midrst_data", 32'(d8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_stays_idle", 32'(ov8), 32'd0);
    txn(1'b0, 16'd9, 16'd9, 1'b0, "after_rst_9x9", 0);
    txn(1'b1, 16'd40000, 16'd50000, 1'b0, "w16_40000x50000", 0);
    txn(1'b1, 16'd1234, 16'd3, 1'b0, "w16_1234x3", 0);
    txn(1'b1, 16'h8000, 16'h8000, 1'b1, "w16_minxmin", 1);
    txn(1'b1, 16'd77, 16'd0, 1'b0, "w16_zero_b", 0);
    for (int i = 0; i < 12; i++) begin
      txn(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), "rand8", int'($urandom_range(0, 2)));
      txn(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), "rand16", int'($urandom_range(0, 2)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised iterative shift-add multiplier, the next generation of the team's fixed 8x8 single-cycle multiplier.
- Processes BitsPerCycle multiplier bits per clock, trading latency for area.
- Adds per-transaction signed/unsigned mode and valid/ready handshakes on both input and output.
- Sits between a producer and a consumer that can each stall.

Parameters:
Width, 8, operand width in bits; must be >= 2.
BitsPerCycle, 1, multiplier bits retired per BUSY cycle; must divide Width exactly.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
in_valid_i  input  1  operands and mode are valid
in_ready_o  output  1  block can accept operands
data_in1_i  input  Width  multiplicand
data_in2_i  input  Width  multiplier
signed_i  input  1  1: both operands two's complement; 0: both unsigned
data_out_o  output  2*Width  product
data_out_valid_o  output  1  product is valid
data_out_ready_i  input  1  consumer accepts product

Behaviour:
- Reset (asynchronous, rst_ni low): state IDLE; in_ready_o=1; data_out_valid_o=0; data_out_o=0; accumulator, operand registers and counter cleared.
- Reset mid-operation aborts the transaction immediately; no output is produced.
- States:
  - IDLE: in_ready_o=1. On in_valid_i&&in_ready_o, go to BUSY. Latch magnitudes |a| and |b| (Width-bit unsigned; the most-negative value maps to 2^(Width-1), which fits). Latch the result sign neg = signed_i & (a_msb ^ b_msb). Clear the accumulator. Counter=0.
  - BUSY: in_ready_o=0. Each cycle: acc += (mcand << shift) * b[BitsPerCycle-1:0]; b >>= BitsPerCycle; counter++. When counter reaches Width/BitsPerCycle-1, go to DONE; the final partial sum is applied that cycle.
  - On entry to DONE: data_out_o = neg ? -acc : acc, truncated to 2*Width bits. data_out_valid_o=1.
  - DONE: in_ready_o=0. data_out_o and data_out_valid_o are held stable until data_out_ready_i=1. On that handshake, go to IDLE; data_out_valid_o=0 next cycle; data_out_o holds its last value.
- Latency: valid rises exactly N = Width/BitsPerCycle cycles after the accept edge.
- Throughput: one result per N+2 cycles at most, without backpressure.
- data_out_ready_i is ignored outside DONE. in_valid_i is ignored outside IDLE; no input is lost because in_ready_o=0 there.
- Operand inputs may change freely after acceptance.
- The accumulator is 2*Width bits and never overflows: the magnitude product is <= (2^Width-1)^2.

Optional Feature:
Macro SEQ_MULTIPLIER_EARLY_TERM_EN.
- Defined: in BUSY, if the remaining shifted multiplier is zero, go to DONE on that cycle. Latency becomes ceil((index of highest set bit of |b| + 1)/BitsPerCycle) cycles, minimum 1. A zero multiplier gives latency 1.
- Undefined: latency is always exactly N.
- Results are identical either way.

Decomposition:
- Package seq_multiplier_pkg holds:
  - state enum state_e {IDLE, BUSY, DONE};
  - function abs_mag(value, is_signed);
  - localparam-style helper for counter width, $clog2(Width/BitsPerCycle).
- Sub-module seq_multiplier_pp: combinational BitsPerCycle-bit partial-product generator plus adder (mcand, shift, b slice, acc in -> acc out). Instantiated once.

Test Plan:
1. Width=8, BitsPerCycle=1, unsigned 2*7 -> data_out_o=14, valid exactly 8 cycles after accept; in_ready_o=0 during BUSY and DONE.
2. Unsigned back-to-back 211*98, 123*77, 255*255, 0*0 with data_out_ready_i=1 -> 20678, 9471, 65025, 0, each accepted only when in_ready_o=1.
3. Signed -3*5 -> 16'hFFF1. -128*-128 -> 16384. -128*127 -> 16'hC080. Unsigned 8'h80*8'h80 -> 16384.
4. Backpressure: hold data_out_ready_i=0 for 5 cycles after valid -> data_out_o and data_out_valid_o stable; in_valid_i pulses not accepted; release -> IDLE next cycle.
5. Reset asserted mid-BUSY on 211*98 -> outputs at reset values immediately; first transaction after reset (9*9) returns 81 with nominal latency.
6. Width=16, BitsPerCycle=4: 40000*50000 -> 2000000000, latency 4. With SEQ_MULTIPLIER_EARLY_TERM_EN defined, 1234*3 -> 3702, latency 1.
